uart_tx_scheduler: RTL and testbench

Transmit-side controller for the Wishbone UART. It buffers bytes written to the TX data register in a small FIFO and sequences the TX frontend one frame at a time, using the frontend's `transmit`/`done` handshake. It sits between the register-access logic (push side) and the TX frontend (`transmit_i`, `dr_i`, `done_o`). It also provides a done-timeout, so a frontend that never completes cannot hang the queue.

---
 rtl/uart_tx_scheduler_if.sv | 32 +++
 rtl/uart_tx_scheduler.sv | 111 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Push-side and TX-frontend signal bundle for uart_tx_scheduler.
// The slave modport is the scheduler; the master modport is whatever drives it.
interface uart_tx_scheduler_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          push_i;
  logic [7:0]    push_data_i;
  logic          flush_i;
  logic          full_o;
  logic          empty_o;
  logic [LW-1:0] level_o;
  logic          busy_o;
  logic          overflow_o;
  logic          timeout_o;
  logic          tx_transmit_o;
  logic [7:0]    tx_dr_o;
  logic          tx_done_i;

  modport slave (
    input  push_i, push_data_i, flush_i, tx_done_i,
    output full_o, empty_o, level_o, busy_o, overflow_o, timeout_o,
           tx_transmit_o, tx_dr_o
  );

  modport master (
    output push_i, push_data_i, flush_i, tx_done_i,
    input  full_o, empty_o, level_o, busy_o, overflow_o, timeout_o,
           tx_transmit_o, tx_dr_o
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: byte FIFO feeding the TX frontend one frame at a
// time via the transmit/done handshake, with an optional done-timeout.
module uart_tx_scheduler #(
  parameter int          DEPTH          = 8,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd0
) (
  input logic                clk_i,
  input logic                rst_i,
  uart_tx_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    dr_q;
  logic [23:0]   tcnt_q;
  logic          ovf_q, to_q;
  logic          full, pop, push_ok, expire;

  assign full    = (count_q == FULL_COUNT);
  assign push_ok = bus.push_i && !full && !bus.flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // done takes priority over an expiry in the same cycle
        if (bus.tx_done_i) begin
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES != 24'd0 && tcnt_q == TIMEOUT_CYCLES - 24'd1) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush_i) begin
      state_d = IDLE;
      pop     = 1'b0;
      expire  = 1'b0;
    end
  end

  always_comb begin
    bus.busy_o        = (state_q != IDLE);
    bus.tx_transmit_o = (state_q == START);
    bus.full_o        = full;
    bus.empty_o       = (count_q == '0);
    bus.level_o       = count_q;
    bus.tx_dr_o       = dr_q;
    bus.overflow_o    = ovf_q;
    bus.timeout_o     = to_q;
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wr_ptr_q] <= bus.push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dr_q     <= 8'h00;
      tcnt_q   <= 24'd0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      ovf_q   <= bus.push_i && full;
      to_q    <= expire;
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        dr_q     <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (state_q == START)     tcnt_q <= 24'd0;
      else if (state_q == WAIT) tcnt_q <= tcnt_q + 24'd1;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed scenarios plus random traffic for uart_tx_scheduler, every cycle
// compared against a queue-based transaction model.
module tb_uart_tx_scheduler;
  localparam int          DEPTH = 4;
  localparam logic [23:0] TMO   = 24'd16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_scheduler_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_scheduler #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: queued bytes, and cycles elapsed since the current frame was popped
  // (-1 = no frame; 1 = start cycle; 2.. = waiting for done).
  logic [7:0] m_q[$];
  int         m_age = -1;
  logic [7:0] m_dr  = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_to  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_edge(input logic p, input logic [7:0] d, input logic f,
                            input logic dn, input logic r);
    logic was_full;
    if (r || f) begin
      m_q.delete();
      m_age = -1;
      m_dr  = 8'h00;
      m_ovf = 1'b0;
      m_to  = 1'b0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      m_ovf    = p && was_full;
      m_to     = 1'b0;
      if (m_age == -1) begin
        if (m_q.size() > 0) begin
          m_dr  = m_q.pop_front();
          m_age = 1;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (dn) begin
        m_age = -1;
      end else if (m_age - 1 == int'(TMO)) begin
        m_to  = 1'b1;
        m_age = -1;
      end else begin
        m_age++;
      end
      if (p && !was_full) m_q.push_back(d);
    end
  endtask

  task automatic check_all();
    chk("level",    32'(bus.level_o),       32'(m_q.size()));
    chk("full",     32'(bus.full_o),        32'(m_q.size() == DEPTH));
    chk("empty",    32'(bus.empty_o),       32'(m_q.size() == 0));
    chk("busy",     32'(bus.busy_o),        32'(m_age != -1));
    chk("transmit", 32'(bus.tx_transmit_o), 32'(m_age == 1));
    chk("dr",       32'(bus.tx_dr_o),       32'(m_dr));
    chk("overflow", 32'(bus.overflow_o),    32'(m_ovf));
    chk("timeout",  32'(bus.timeout_o),     32'(m_to));
  endtask

  task automatic step(input logic p, input logic [7:0] d, input logic f,
                      input logic dn, input logic r);
    bus.push_i      = p;
    bus.push_data_i = d;
    bus.flush_i     = f;
    bus.tx_done_i   = dn;
    rst             = r;
    @(posedge clk);
    model_edge(p, d, f, dn, r);
    #1;
    check_all();
    if (bus.tx_transmit_o) $display("t=%0t start byte 0x%02h", $time, bus.tx_dr_o);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_tx(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      n++;
      if (bus.tx_transmit_o) break;
    end
    chk("wait_tx", 32'(bus.tx_transmit_o), 32'd1);
  endtask

  initial begin
    int n;
    int pulses;
    int guard;
    logic [7:0] ord[3];
    ord[0] = 8'h11; ord[1] = 8'h22; ord[2] = 8'h33;
    bus.push_i = 1'b0; bus.push_data_i = 8'h00; bus.flush_i = 1'b0; bus.tx_done_i = 1'b0;

    // Reset held two cycles with a push pending
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    chk("rst_full", 32'(bus.full_o), 32'd0);
    chk("rst_empty", 32'(bus.empty_o), 32'd1);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_transmit", 32'(bus.tx_transmit_o), 32'd0);
    chk("rst_dr", 32'(bus.tx_dr_o), 32'h00);
    chk("rst_ovf", 32'(bus.overflow_o), 32'd0);
    chk("rst_to", 32'(bus.timeout_o), 32'd0);
    idle(1);
    chk("rst_level", 32'(bus.level_o), 32'd0);

    // Single byte
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("sb_empty", 32'(bus.empty_o), 32'd0);
    chk("sb_level", 32'(bus.level_o), 32'd1);
    idle(1);
    chk("sb_start", 32'(bus.tx_transmit_o), 32'd1);
    chk("sb_dr", 32'(bus.tx_dr_o), 32'hA5);
    pulses = 0;
    repeat (5) begin
      idle(1);
      pulses += int'(bus.tx_transmit_o);
      chk("sb_busy_wait", 32'(bus.busy_o), 32'd1);
    end
    chk("sb_extra_pulses", 32'(pulses), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("sb_busy_done", 32'(bus.busy_o), 32'd0);
    chk("sb_empty_done", 32'(bus.empty_o), 32'd1);

    // Ordering with done 10 cycles after each start
    step(1'b1, ord[0], 1'b0, 1'b0, 1'b0);
    step(1'b1, ord[1], 1'b0, 1'b0, 1'b0);
    chk("ord_start0", 32'(bus.tx_transmit_o), 32'd1);
    chk("ord_dr0", 32'(bus.tx_dr_o), 32'(ord[0]));
    step(1'b1, ord[2], 1'b0, 1'b0, 1'b0);
    idle(8);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k < 3; k++) begin
      wait_tx(20, n);
      chk("ord_gap", 32'(n + 1), 32'd2);
      chk("ord_dr", 32'(bus.tx_dr_o), 32'(ord[k]));
      idle(9);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("ord_empty", 32'(bus.empty_o), 32'd1);
    chk("ord_idle", 32'(bus.busy_o), 32'd0);

    // Overflow with the frontend stalled
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
      pulses += int'(bus.overflow_o);
      if (i == 4) begin
        chk("ovf_full", 32'(bus.full_o), 32'd1);
        chk("ovf_level4", 32'(bus.level_o), 32'd4);
      end
    end
    chk("ovf_pulse", 32'(bus.overflow_o), 32'd1);
    idle(1);
    chk("ovf_clear", 32'(bus.overflow_o), 32'd0);
    chk("ovf_count", 32'(pulses), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("pp_level_before", 32'(bus.level_o), 32'd2);
    step(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
    chk("pp_level", 32'(bus.level_o), 32'd2);
    chk("pp_start", 32'(bus.tx_transmit_o), 32'd1);
    guard = 0;
    while (!(bus.empty_o && !bus.busy_o) && guard < 100) begin
      step(1'b0, 8'h00, 1'b0, bus.busy_o && !bus.tx_transmit_o, 1'b0);
      guard++;
    end
    chk("drain_empty", 32'(bus.empty_o), 32'd1);

    // Flush mid-frame together with a push
    step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 8'hC4, 1'b1, 1'b0, 1'b0);
    chk("fl_level", 32'(bus.level_o), 32'd0);
    chk("fl_busy", 32'(bus.busy_o), 32'd0);
    chk("fl_dr", 32'(bus.tx_dr_o), 32'h00);
    chk("fl_ovf", 32'(bus.overflow_o), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    pulses = 0;
    repeat (3) begin
      idle(1);
      pulses += int'(bus.tx_transmit_o);
    end
    chk("fl_no_start", 32'(pulses), 32'd0);

    // Timeout: TMO wait cycles, then a registered pulse
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h6B, 1'b0, 1'b0, 1'b0);
    chk("to_start", 32'(bus.tx_dr_o), 32'h5A);
    n = 0;
    while (n < 30) begin
      idle(1);
      n++;
      if (bus.timeout_o) break;
    end
    chk("to_pulse", 32'(bus.timeout_o), 32'd1);
    chk("to_latency", 32'(n), 32'(TMO) + 32'd1);
    idle(1);
    chk("to_once", 32'(bus.timeout_o), 32'd0);
    chk("to_next_start", 32'(bus.tx_transmit_o), 32'd1);
    chk("to_next_dr", 32'(bus.tx_dr_o), 32'h6B);
    idle(int'(TMO));
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("to_done_wins", 32'(bus.timeout_o), 32'd0);
    chk("to_done_idle", 32'(bus.busy_o), 32'd0);
    idle(1);
    chk("to_done_after", 32'(bus.timeout_o), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 63) == 0,
           $urandom_range(0, 7) == 0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
